// File: rtl/counter_nbit_prog_if.sv
// Control/status bundle for counter_nbit_prog: the master drives configuration
// and strobes, the slave (the counter) returns the registered count state.
interface counter_nbit_prog_if #(
  parameter int WIDTH          = 32,
  parameter int PRESCALE_WIDTH = 8
);
  logic                      enable;
  logic                      clear;
  logic                      load;
  logic [WIDTH-1:0]          load_value;
  logic [WIDTH-1:0]          max_value;
  logic [WIDTH-1:0]          step;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic                      direction;
  logic [1:0]                mode;
  logic [WIDTH-1:0]          count_value;
  logic                      terminal;
  logic                      done;
  logic                      count_dir;

  modport master (
    output enable, clear, load, load_value, max_value, step, prescale, direction, mode,
    input  count_value, terminal, done, count_dir
  );

  modport slave (
    input  enable, clear, load, load_value, max_value, step, prescale, direction, mode,
    output count_value, terminal, done, count_dir
  );
endinterface

// File: rtl/counter_nbit_prog.sv
// Programmable N-bit counter with prescaler, run-time limit/step/direction and
// wrap, saturate, one-shot and triangle modes; all outputs registered.
module counter_nbit_prog #(
  parameter int WIDTH          = 32,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                clock,
  input  logic                reset,
  counter_nbit_prog_if.slave  bus
);

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_TRI     = 2'b11
  } mode_e;

  mode_e                     mode;
  logic [WIDTH-1:0]          count_q, count_d;
  logic [PRESCALE_WIDTH-1:0] pre_q, pre_d;
  logic                      term_q, term_d;
  logic                      done_q, done_d;
  logic                      dir_q, dir_d;

  logic                      tick;
  logic [WIDTH:0]            up_sum;
  logic [WIDTH-1:0]          up_next, dn_next;
  logic                      up_ovf, dn_unf;

  assign mode = mode_e'(bus.mode);

  // Comparing with >= lets a prescale lowered below pre_cnt still fire and re-phase.
  assign tick = bus.enable && (pre_q >= bus.prescale);

  // One extra bit keeps count+step from wrapping silently past 2^WIDTH-1.
  assign up_sum  = {1'b0, count_q} + {1'b0, bus.step};
  assign up_ovf  = up_sum > {1'b0, bus.max_value};
  assign dn_unf  = count_q < bus.step;
  assign up_next = up_ovf ? bus.max_value : up_sum[WIDTH-1:0];
  assign dn_next = dn_unf ? '0 : (count_q - bus.step);

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path infers a latch.
    count_d = count_q;
    pre_d   = pre_q;
    term_d  = 1'b0;
    done_d  = (mode == MODE_ONESHOT) ? done_q : 1'b0;
    dir_d   = dir_q;

    if (bus.clear) begin
      count_d = '0;
      pre_d   = '0;
      done_d  = 1'b0;
      dir_d   = 1'b1;
    end else if (bus.load) begin
      count_d = (bus.load_value > bus.max_value) ? bus.max_value : bus.load_value;
      pre_d   = '0;
      done_d  = 1'b0;
      if (bus.enable && mode != MODE_TRI) dir_d = bus.direction;
    end else if (bus.enable) begin
      pre_d = tick ? '0 : pre_q + 1'b1;
      if (mode != MODE_TRI) dir_d = bus.direction;

      if (tick) begin
        unique case (mode)
          MODE_WRAP, MODE_ONESHOT: begin
            if (!(mode == MODE_ONESHOT && done_q)) begin
              if (bus.direction) begin
                count_d = up_ovf ? '0 : up_sum[WIDTH-1:0];
                term_d  = up_ovf;
              end else begin
                count_d = dn_unf ? bus.max_value : dn_next;
                term_d  = dn_unf;
              end
              if (mode == MODE_ONESHOT && term_d) done_d = 1'b1;
            end
          end
          MODE_SAT: begin
            // Pulse only on arrival at the limit, never while parked on it.
            if (bus.direction) begin
              count_d = up_next;
              term_d  = (up_next == bus.max_value) && (count_q != bus.max_value);
            end else begin
              count_d = dn_next;
              term_d  = (dn_next == '0) && (count_q != '0);
            end
          end
          MODE_TRI: begin
            if (dir_q) begin
              count_d = up_next;
              if (up_next == bus.max_value) dir_d = 1'b0;
            end else begin
              count_d = dn_next;
              if (dn_next == '0) begin
                dir_d  = 1'b1;
                term_d = (bus.step != '0);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      pre_q   <= '0;
      term_q  <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= 1'b1;
    end else begin
      count_q <= count_d;
      pre_q   <= pre_d;
      term_q  <= term_d;
      done_q  <= done_d;
      dir_q   <= dir_d;
    end
  end

  assign bus.count_value = count_q;
  assign bus.terminal    = term_q;
  assign bus.done        = done_q;
  assign bus.count_dir   = dir_q;

endmodule

// File: tb/tb_counter_nbit_prog.sv
// Directed bench for counter_nbit_prog (WIDTH=8) with hand-computed expectations
// covering every mode, prescaling, enable freeze, priority and boundary cases.
module tb_counter_nbit_prog;
  localparam int W  = 8;
  localparam int PW = 4;

  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;

  counter_nbit_prog_if #(.WIDTH(W), .PRESCALE_WIDTH(PW)) bus ();

  counter_nbit_prog #(.WIDTH(W), .PRESCALE_WIDTH(PW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    cyc();
    bus.clear = 1'b0;
  endtask

  // Wrap up, max=3 step=1 prescale=0
  int wrap_c [6] = '{1, 2, 3, 0, 1, 2};
  int wrap_t [6] = '{0, 0, 0, 1, 0, 0};
  // Prescale=2 down from 2, max=5, with a 4-cycle enable gap
  int pre_en [13] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1};
  int pre_c  [13] = '{2, 2, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 5};
  int pre_t  [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
  // Saturate up, max=10 step=4
  int sat_c [5] = '{4, 8, 10, 10, 10};
  int sat_t [5] = '{0, 0, 1, 0, 0};
  // One-shot up, max=2
  int os_c [5] = '{1, 2, 0, 0, 0};
  int os_t [5] = '{0, 0, 1, 0, 0};
  int os_d [5] = '{0, 0, 1, 1, 1};
  // Triangle, max=3 step=1
  int tri_c [7] = '{1, 2, 3, 2, 1, 0, 1};
  int tri_t [7] = '{0, 0, 0, 0, 0, 1, 0};
  int tri_d [7] = '{1, 1, 0, 0, 0, 1, 1};

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset          = 1'b0;
    bus.enable     = 1'b0;
    bus.clear      = 1'b0;
    bus.load       = 1'b0;
    bus.load_value = '0;
    bus.max_value  = 8'd3;
    bus.step       = 8'd1;
    bus.prescale   = '0;
    bus.direction  = 1'b1;
    bus.mode       = 2'b00;
    repeat (2) cyc();
    check("rst_count", bus.count_value, 0);
    check("rst_term",  bus.terminal,    0);
    check("rst_done",  bus.done,        0);
    check("rst_dir",   bus.count_dir,   1);
    reset = 1'b1;

    bus.enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      check($sformatf("wrap_c%0d", i), bus.count_value, wrap_c[i]);
      check($sformatf("wrap_t%0d", i), bus.terminal,    wrap_t[i]);
    end

    bus.prescale   = 4'd2;
    bus.direction  = 1'b0;
    bus.max_value  = 8'd5;
    bus.load_value = 8'd2;
    bus.load       = 1'b1;
    cyc();
    bus.load = 1'b0;
    check("pre_load", bus.count_value, 2);
    check("pre_dir",  bus.count_dir,   0);
    for (int i = 0; i < 13; i++) begin
      bus.enable = pre_en[i][0];
      cyc();
      check($sformatf("pre_c%0d", i), bus.count_value, pre_c[i]);
      check($sformatf("pre_t%0d", i), bus.terminal,    pre_t[i]);
    end

    bus.mode      = 2'b01;
    bus.prescale  = '0;
    bus.direction = 1'b1;
    bus.max_value = 8'd10;
    bus.step      = 8'd4;
    pulse_clear();
    check("sat_clr", bus.count_value, 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check($sformatf("sat_c%0d", i), bus.count_value, sat_c[i]);
      check($sformatf("sat_t%0d", i), bus.terminal,    sat_t[i]);
    end
    bus.load_value = 8'd20;
    bus.load       = 1'b1;
    cyc();
    bus.load = 1'b0;
    check("sat_load_clamp", bus.count_value, 10);
    check("sat_load_term",  bus.terminal,    0);

    bus.mode      = 2'b10;
    bus.max_value = 8'd2;
    bus.step      = 8'd1;
    pulse_clear();
    check("os_clr", bus.count_value, 0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check($sformatf("os_c%0d", i), bus.count_value, os_c[i]);
      check($sformatf("os_t%0d", i), bus.terminal,    os_t[i]);
      check($sformatf("os_d%0d", i), bus.done,        os_d[i]);
    end
    pulse_clear();
    check("os_rearm_done", bus.done, 0);
    cyc();
    check("os_rearm_c", bus.count_value, 1);
    bus.direction = 1'b0;
    cyc();
    check("os_pre_rst_dir", bus.count_dir, 0);
    #3 reset = 1'b0;
    #1;
    check("async_rst_count", bus.count_value, 0);
    check("async_rst_term",  bus.terminal,    0);
    check("async_rst_done",  bus.done,        0);
    check("async_rst_dir",   bus.count_dir,   1);
    bus.enable = 1'b0;
    cyc();
    reset = 1'b1;

    bus.mode      = 2'b11;
    bus.max_value = 8'd3;
    bus.step      = 8'd1;
    bus.enable    = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cyc();
      check($sformatf("tri_c%0d", i), bus.count_value, tri_c[i]);
      check($sformatf("tri_t%0d", i), bus.terminal,    tri_t[i]);
      check($sformatf("tri_d%0d", i), bus.count_dir,   tri_d[i]);
    end

    bus.mode       = 2'b00;
    bus.direction  = 1'b1;
    bus.max_value  = 8'd200;
    bus.load_value = 8'd7;
    bus.clear      = 1'b1;
    bus.load       = 1'b1;
    cyc();
    bus.clear = 1'b0;
    check("prio_clr_over_load", bus.count_value, 0);
    cyc();
    bus.load = 1'b0;
    check("prio_load_c", bus.count_value, 7);
    check("prio_load_t", bus.terminal,    0);

    bus.max_value  = 8'd255;
    bus.step       = 8'd2;
    bus.load_value = 8'd254;
    bus.load       = 1'b1;
    cyc();
    bus.load = 1'b0;
    check("max_load", bus.count_value, 254);
    cyc();
    check("max_ovf_c", bus.count_value, 0);
    check("max_ovf_t", bus.terminal,    1);

    bus.step       = 8'd1;
    bus.load_value = 8'd5;
    bus.load       = 1'b1;
    cyc();
    bus.load      = 1'b0;
    bus.max_value = 8'd3;
    cyc();
    check("lowmax_wrap_c", bus.count_value, 0);
    check("lowmax_wrap_t", bus.terminal,    1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
